// File: rtl/xnor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xnor_pkg
//  Description : Shared types and constants for the bit-serial XNOR arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package xnor_pkg;

    // Default operand width in bits
    localparam int c_DEFAULT_W = 8;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : xnor_pkg
`default_nettype wire

// File: rtl/xnor_bit.sv
`default_nettype none
// ============================================================================
//  Module      : xnor_bit
//  Description : Single-bit XNOR element, time-shared by the arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module xnor_bit (
    input  logic A,
    input  logic B,
    output logic Y
);

    assign Y = ~(A ^ B);

endmodule : xnor_bit
`default_nettype wire

// File: rtl/xnor_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : xnor_share_arb
//  Description : Two-requester round-robin arbiter feeding one shared 1-bit
//                XNOR element. The granted operand pair is processed LSB to
//                MSB, one bit per cycle, while the count of ones accumulates.
//                The result is then held until the consumer takes it.
//  Revision    : 1.0  initial release
// ============================================================================
module xnor_share_arb
    import xnor_pkg::*;
#(
    parameter int W = c_DEFAULT_W
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   req0_valid,
    input  logic [W-1:0]           req0_a,
    input  logic [W-1:0]           req0_b,
    output logic                   req0_ready,

    input  logic                   req1_valid,
    input  logic [W-1:0]           req1_a,
    input  logic [W-1:0]           req1_b,
    output logic                   req1_ready,

    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [W-1:0]           rsp_y,
    output logic [$clog2(W+1)-1:0] rsp_ones,
    output logic                   rsp_match,

    output logic                   busy
);

    localparam int IDX_W  = $clog2(W);
    localparam int ONES_W = $clog2(W+1);

    localparam logic [IDX_W-1:0]  c_LAST_IDX = IDX_W'(W - 1);
    localparam logic [ONES_W-1:0] c_ALL_ONES = ONES_W'(W);

    state_t              r_state;
    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic [W-1:0]        r_y;
    logic [IDX_W-1:0]    r_idx;
    logic [ONES_W-1:0]   r_ones;
    logic                r_id;
    logic                r_last;
    logic                r_rsp_valid;
    logic                r_busy;

    logic                w_gnt_id;
    logic                w_accept;
    logic [W-1:0]        w_gnt_a;
    logic [W-1:0]        w_gnt_b;
    logic                w_a_bit;
    logic                w_b_bit;
    logic                w_y_bit;

    // Round-robin pick: on contention favour whoever was not served last
    always_comb begin
        w_gnt_id = 1'b0;
        if (req0_valid && req1_valid) begin
            w_gnt_id = ~r_last;
        end else if (req1_valid) begin
            w_gnt_id = 1'b1;
        end
        w_accept = (r_state == IDLE) && !rst && (req0_valid || req1_valid);
        w_gnt_a  = w_gnt_id ? req1_a : req0_a;
        w_gnt_b  = w_gnt_id ? req1_b : req0_b;
    end

    assign req0_ready = w_accept && !w_gnt_id;
    assign req1_ready = w_accept &&  w_gnt_id;

    // The captured copies feed the shared element, so later input changes
    // on a requester cannot disturb the in-flight operation.
    assign w_a_bit = r_a[r_idx];
    assign w_b_bit = r_b[r_idx];

    xnor_bit u_xnor_bit (
        .A (w_a_bit),
        .B (w_b_bit),
        .Y (w_y_bit)
    );

    // Controller: arbitration capture, serial evaluation and response hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_y         <= '0;
            r_idx       <= '0;
            r_ones      <= '0;
            r_id        <= 1'b0;
            r_last      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_gnt_a;
                        r_b     <= w_gnt_b;
                        r_id    <= w_gnt_id;
                        r_last  <= w_gnt_id;
                        r_idx   <= '0;
                        r_ones  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_y[r_idx] <= w_y_bit;
                    r_ones     <= r_ones + ONES_W'(w_y_bit);
                    if (r_idx == c_LAST_IDX) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_y     = r_y;
    assign rsp_ones  = r_ones;
    assign rsp_match = (r_ones == c_ALL_ONES);
    assign busy      = r_busy;

endmodule : xnor_share_arb
`default_nettype wire
